// File: rtl/interrupt_controller.sv
// Interrupt controller with per-channel synchronisers, edge capture, masking and a
// three-state presentation FSM (IDLE -> PRESENT -> CLEAR). Lowest pending unmasked
// channel wins. Optional per-channel level mode is compiled in with INTCTRL_LEVEL_MODE_EN.
module interrupt_controller #(
    parameter int unsigned NUM_IRQ     = 4,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned ID_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_d,
    input  logic               irq_ack,
    output logic               irq_out,
    output logic [ID_W-1:0]    irq_id,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] overrun,
    output logic [NUM_IRQ-1:0] mask
`ifdef INTCTRL_LEVEL_MODE_EN
    ,
    input  logic               mode_we,
    input  logic [NUM_IRQ-1:0] mode_d
`endif
);

    typedef enum logic [1:0] {StIdle, StPresent, StClear} state_e;

    state_e             state_q, state_d;
    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] synced;
    logic [NUM_IRQ-1:0] prev_q;
    logic [NUM_IRQ-1:0] rise;
    logic [SYNC_STAGES:0] arm_q;
    logic               armed;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] overrun_q, overrun_d;
    logic [NUM_IRQ-1:0] mask_q;
    logic [NUM_IRQ-1:0] level_mode;
    logic [NUM_IRQ-1:0] ack_clr;
    logic [NUM_IRQ-1:0] req;
    logic [ID_W-1:0]    id_q, id_d, lowest;
    logic               ack_take;

    // Synchroniser chain per channel
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int k = 0; k < int'(SYNC_STAGES); k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int k = 1; k < int'(SYNC_STAGES); k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // Edge register plus arming shift register. The first compare after reset pits the
    // first real sample against reset zeros, so it is suppressed: an input already high
    // at release never looks like a rising edge.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            prev_q <= '0;
            arm_q  <= '0;
        end else begin
            prev_q <= synced;
            arm_q  <= {arm_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign armed = arm_q[SYNC_STAGES];
    assign rise  = armed ? (synced & ~prev_q) : '0;

    // Mask register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            mask_q <= '0;
        end else if (mask_we) begin
            mask_q <= mask_d;
        end
    end

`ifdef INTCTRL_LEVEL_MODE_EN
    logic [NUM_IRQ-1:0] mode_q;

    // Per-channel mode register: 1 = level-sensitive
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            mode_q <= '0;
        end else if (mode_we) begin
            mode_q <= mode_d;
        end
    end

    assign level_mode = mode_q;
`else
    assign level_mode = '0;
`endif

    assign ack_take = (state_q == StPresent) && irq_ack;

    // Decode the acknowledged channel
    always_comb begin
        ack_clr = '0;
        if (ack_take) ack_clr[id_q] = 1'b1;
    end

    // Pending/overrun next state; a new edge beats a simultaneous ack-clear
    always_comb begin
        pending_d = pending_q;
        overrun_d = overrun_q;
        for (int i = 0; i < int'(NUM_IRQ); i++) begin
            if (level_mode[i]) begin
                pending_d[i] = synced[i];
                overrun_d[i] = 1'b0;
            end else begin
                pending_d[i] = rise[i] | (pending_q[i] & ~ack_clr[i]);
                overrun_d[i] = ~ack_clr[i] & (overrun_q[i] | (rise[i] & pending_q[i]));
            end
        end
    end

    // Pending and overrun flags
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign req = pending_q & mask_q;

    // Lowest-index requesting channel
    always_comb begin
        lowest = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (req[i]) lowest = ID_W'(i);
        end
    end

    // FSM next state and presented id
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d = StPresent;
                    id_d    = lowest;
                end
            end
            StPresent: begin
                if (irq_ack) state_d = StClear;
            end
            StClear: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM state and presented id registers
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= StIdle;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
        end
    end

    assign irq_out = (state_q == StPresent);
    assign irq_id  = id_q;
    assign pending = pending_q;
    assign overrun = overrun_q;
    assign mask    = mask_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller (default build, edge mode only).
module tb_interrupt_controller;

    localparam int unsigned N    = 4;
    localparam int unsigned S    = 2;
    localparam int unsigned ID_W = 2;

    logic            clk;
    logic            nreset;
    logic [N-1:0]    irq_in;
    logic            mask_we;
    logic [N-1:0]    mask_d;
    logic            irq_ack;
    logic            irq_out;
    logic [ID_W-1:0] irq_id;
    logic [N-1:0]    pending;
    logic [N-1:0]    overrun;
    logic [N-1:0]    mask;

    int n_assert;
    int n_fail;

    typedef struct packed {
        logic            out;
        logic [ID_W-1:0] id;
        logic [N-1:0]    pend;
        logic [N-1:0]    ovr;
        logic [N-1:0]    msk;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    interrupt_controller #(
        .NUM_IRQ     (N),
        .SYNC_STAGES (S)
    ) dut (
        .clk     (clk),
        .nreset  (nreset),
        .irq_in  (irq_in),
        .mask_we (mask_we),
        .mask_d  (mask_d),
        .irq_ack (irq_ack),
        .irq_out (irq_out),
        .irq_id  (irq_id),
        .pending (pending),
        .overrun (overrun),
        .mask    (mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input string tag, input logic o, input logic [ID_W-1:0] id,
                        input logic [N-1:0] pend, input logic [N-1:0] ovr,
                        input logic [N-1:0] msk);
        exp_t e;
        e.out  = o;
        e.id   = id;
        e.pend = pend;
        e.ovr  = ovr;
        e.msk  = msk;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_pop();
        exp_t  e;
        string t;
        if (exp_q.size() == 0) begin
            $display("FAIL scoreboard: observed empty queue expected an entry");
            n_fail++;
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk({t, ".irq_out"}, 32'(irq_out), 32'(e.out));
        // irq_id is only meaningful while an interrupt is presented
        if (e.out) chk({t, ".irq_id"}, 32'(irq_id), 32'(e.id));
        chk({t, ".pending"}, 32'(pending), 32'(e.pend));
        chk({t, ".overrun"}, 32'(overrun), 32'(e.ovr));
        chk({t, ".mask"}, 32'(mask), 32'(e.msk));
    endtask

    task automatic expect_now(input string tag, input logic o, input logic [ID_W-1:0] id,
                              input logic [N-1:0] pend, input logic [N-1:0] ovr,
                              input logic [N-1:0] msk);
        push(tag, o, id, pend, ovr, msk);
        check_pop();
    endtask

    task automatic wait_present(input int max);
        int i;
        i = 0;
        while (irq_out !== 1'b1 && i < max) begin
            tick();
            i++;
        end
    endtask

    task automatic write_mask(input logic [N-1:0] m);
        mask_d  = m;
        mask_we = 1'b1;
        tick();
        mask_we = 1'b0;
    endtask

    task automatic ack_pulse();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        nreset   = 1'b0;
        irq_in   = '0;
        mask_we  = 1'b0;
        mask_d   = '0;
        irq_ack  = 1'b0;

        #12;
        expect_now("reset", 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000);
        chk("reset.irq_id", 32'(irq_id), 32'd0);
        @(negedge clk);
        nreset = 1'b1;
        repeat (S + 3) tick();

        // Exact latency from input rise to presentation
        write_mask(4'b0001);
        expect_now("maskwr", 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0001);
        irq_in[0] = 1'b1;
        push("latency", 1'b1, 2'd0, 4'b0001, 4'b0000, 4'b0001);
        for (int i = 0; i < int'(S) + 1; i++) begin
            tick();
            chk("latency.early_out", 32'(irq_out), 32'd0);
        end
        chk("latency.pending_set", 32'(pending), 32'h1);
        tick();
        check_pop();
        ack_pulse();
        expect_now("ack0", 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0001);
        tick();
        expect_now("clear0", 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0001);
        irq_in[0] = 1'b0;
        repeat (S + 2) tick();
        chk("idle0.irq_out", 32'(irq_out), 32'd0);

        // Priority: channels 1 and 3 together
        write_mask(4'b1111);
        irq_in = 4'b1010;
        push("prio", 1'b1, 2'd1, 4'b1010, 4'b0000, 4'b1111);
        repeat (S + 2) tick();
        check_pop();
        ack_pulse();
        expect_now("prio.ack", 1'b0, 2'd0, 4'b1000, 4'b0000, 4'b1111);
        push("prio.next", 1'b1, 2'd3, 4'b1000, 4'b0000, 4'b1111);
        wait_present(4);
        check_pop();
        ack_pulse();
        expect_now("prio.ack3", 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b1111);
        irq_in = '0;
        repeat (S + 3) tick();

        // Overrun on second edge while pending
        irq_in[2] = 1'b1;
        repeat (S + 2) tick();
        expect_now("ovr.pres", 1'b1, 2'd2, 4'b0100, 4'b0000, 4'b1111);
        irq_in[2] = 1'b0;
        repeat (S + 1) tick();
        irq_in[2] = 1'b1;
        push("ovr.set", 1'b1, 2'd2, 4'b0100, 4'b0100, 4'b1111);
        repeat (S + 1) tick();
        check_pop();
        ack_pulse();
        expect_now("ovr.ack", 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b1111);
        irq_in[2] = 1'b0;
        repeat (S + 3) tick();

        // Edge coincident with ack-clear: set wins, no overrun
        irq_in[2] = 1'b1;
        repeat (S + 2) tick();
        expect_now("race.pres", 1'b1, 2'd2, 4'b0100, 4'b0000, 4'b1111);
        irq_in[2] = 1'b0;
        repeat (S + 1) tick();
        irq_in[2] = 1'b1;
        repeat (S) tick();
        ack_pulse();
        expect_now("race.setwins", 1'b0, 2'd0, 4'b0100, 4'b0000, 4'b1111);
        push("race.repres", 1'b1, 2'd2, 4'b0100, 4'b0000, 4'b1111);
        wait_present(4);
        check_pop();
        ack_pulse();
        expect_now("race.ack", 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b1111);
        irq_in[2] = 1'b0;
        repeat (S + 3) tick();

        // Masked channel stays pending, ack outside PRESENT ignored, presents on unmask
        write_mask(4'b0000);
        irq_in[0] = 1'b1;
        repeat (S + 2) tick();
        expect_now("masked", 1'b0, 2'd0, 4'b0001, 4'b0000, 4'b0000);
        ack_pulse();
        expect_now("ack_idle", 1'b0, 2'd0, 4'b0001, 4'b0000, 4'b0000);
        push("unmask", 1'b1, 2'd0, 4'b0001, 4'b0000, 4'b0001);
        write_mask(4'b0001);
        chk("unmask.first", 32'(irq_out), 32'd0);
        tick();
        check_pop();
        write_mask(4'b0000);
        expect_now("hold_on_mask", 1'b1, 2'd0, 4'b0001, 4'b0000, 4'b0000);
        ack_pulse();
        expect_now("hold.ack", 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000);

        // Asynchronous reset during PRESENT, inputs held high through release
        write_mask(4'b1111);
        irq_in = 4'b0011;
        repeat (S + 2) tick();
        expect_now("rst.pres", 1'b1, 2'd1, 4'b0010, 4'b0000, 4'b1111);
        #2;
        nreset = 1'b0;
        #1;
        expect_now("rst.async", 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000);
        chk("rst.async.irq_id", 32'(irq_id), 32'd0);
        @(negedge clk);
        nreset = 1'b1;
        write_mask(4'b1111);
        for (int i = 0; i < 2 * int'(S) + 6; i++) begin
            tick();
            chk("rst.release.irq_out", 32'(irq_out), 32'd0);
            chk("rst.release.pending", 32'(pending), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
